// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor (2-bit BHT + direct-mapped BTB) with an
// execute-side resolver that detects mispredictions, issues a registered
// redirect/flush, trains the tables and keeps performance counters.
module branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_if_pc,
  output logic            o_pred_take,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_ex_valid,
  input  logic            i_ex_isBranch,
  input  logic            i_ex_isJal,
  input  logic            i_ex_isJalr,
  input  logic [2:0]      i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_rs1,
  input  logic [XLEN-1:0] i_ex_rs2,
  input  logic [XLEN-1:0] i_ex_imm,
  input  logic            i_ex_pred_take,
  input  logic [XLEN-1:0] i_ex_pred_target,
  output logic            o_flush,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [31:0]     o_branch_count,
  output logic [31:0]     o_mispredict_count
);

  localparam int unsigned BHT_IDX = $clog2(BHT_ENTRIES);
  localparam int unsigned BTB_IDX = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W   = XLEN - 2 - BTB_IDX;

  logic [1:0]       bht        [BHT_ENTRIES];
  logic             btb_valid  [BTB_ENTRIES];
  logic             btb_jump   [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target [BTB_ENTRIES];

  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  // Fetch-side lookup, zero latency
  logic [BHT_IDX-1:0] if_bht_idx;
  logic [BTB_IDX-1:0] if_btb_idx;
  logic [TAG_W-1:0]   if_tag;
  logic               if_hit;

  assign if_bht_idx    = i_if_pc[BHT_IDX+1:2];
  assign if_btb_idx    = i_if_pc[BTB_IDX+1:2];
  assign if_tag        = i_if_pc[XLEN-1:BTB_IDX+2];
  assign if_hit        = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
  assign o_pred_take   = if_hit && (btb_jump[if_btb_idx] || bht[if_bht_idx][1]);
  assign o_pred_target = o_pred_take ? btb_target[if_btb_idx] : i_if_pc + XLEN'(4);

  // Execute-side decode; JALR outranks JAL outranks branch
  logic [BHT_IDX-1:0] ex_bht_idx;
  logic [BTB_IDX-1:0] ex_btb_idx;
  logic [TAG_W-1:0]   ex_tag;
  logic               ex_hit;
  logic               is_jalr;
  logic               is_jal;
  logic               is_br;
  logic               is_cf;
  logic               br_cond;
  logic               act_take;
  logic [XLEN-1:0]    act_target;
  logic [XLEN-1:0]    act_next;
  logic               mispredict;

  assign ex_bht_idx = i_ex_pc[BHT_IDX+1:2];
  assign ex_btb_idx = i_ex_pc[BTB_IDX+1:2];
  assign ex_tag     = i_ex_pc[XLEN-1:BTB_IDX+2];
  assign ex_hit     = btb_valid[ex_btb_idx] && (btb_tag[ex_btb_idx] == ex_tag);

  assign is_jalr = i_ex_valid && i_ex_isJalr;
  assign is_jal  = i_ex_valid && i_ex_isJal && !i_ex_isJalr;
  // funct3 010/011 are not branch encodings; such slots behave as plain instructions
  assign is_br   = i_ex_valid && i_ex_isBranch && !i_ex_isJal && !i_ex_isJalr &&
                   (i_ex_funct3[2:1] != 2'b01);
  assign is_cf   = is_jalr || is_jal || is_br;

  // Branch condition evaluation
  always_comb begin
    br_cond = 1'b0;
    case (i_ex_funct3)
      3'b000:  br_cond = (i_ex_rs1 == i_ex_rs2);
      3'b001:  br_cond = (i_ex_rs1 != i_ex_rs2);
      3'b100:  br_cond = ($signed(i_ex_rs1) <  $signed(i_ex_rs2));
      3'b101:  br_cond = ($signed(i_ex_rs1) >= $signed(i_ex_rs2));
      3'b110:  br_cond = (i_ex_rs1 <  i_ex_rs2);
      3'b111:  br_cond = (i_ex_rs1 >= i_ex_rs2);
      default: br_cond = 1'b0;
    endcase
  end

  assign act_take   = is_jal || is_jalr || (is_br && br_cond);
  assign act_target = is_jalr ? ((i_ex_rs1 + i_ex_imm) & ~XLEN'(1)) : (i_ex_pc + i_ex_imm);
  assign act_next   = act_take ? act_target : (i_ex_pc + XLEN'(4));
  assign mispredict = i_ex_valid &&
                      ((act_take != i_ex_pred_take) ||
                       (act_take && i_ex_pred_take && (act_target != i_ex_pred_target)));

  // BHT training: saturating 2-bit counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[BHT_IDX'(i)] <= 2'b01;
    end else if (is_br) begin
      if (br_cond && (bht[ex_bht_idx] != 2'b11))
        bht[ex_bht_idx] <= bht[ex_bht_idx] + 2'd1;
      else if (!br_cond && (bht[ex_bht_idx] != 2'b00))
        bht[ex_bht_idx] <= bht[ex_bht_idx] - 2'd1;
    end
  end

  // BTB valid bits: set on taken control flow, cleared on an aliasing hit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) btb_valid[BTB_IDX'(i)] <= 1'b0;
    end else if (act_take) begin
      btb_valid[ex_btb_idx] <= 1'b1;
    end else if (i_ex_valid && !is_cf && ex_hit) begin
      btb_valid[ex_btb_idx] <= 1'b0;
    end
  end

  // BTB payload, qualified by the valid bits so no reset is needed
  always_ff @(posedge i_clk) begin
    if (act_take) begin
      btb_jump[ex_btb_idx]   <= is_jal || is_jalr;
      btb_tag[ex_btb_idx]    <= ex_tag;
      btb_target[ex_btb_idx] <= act_target;
    end
  end

  // Registered single-cycle flush/redirect and performance counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_flush          <= 1'b0;
      o_redirect_pc    <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      o_flush <= mispredict;
      if (mispredict) begin
        o_redirect_pc    <= act_next;
        mispredict_count <= mispredict_count + 32'd1;
      end
      if (is_cf) branch_count <= branch_count + 32'd1;
    end
  end

  assign o_branch_count     = branch_count;
  assign o_mispredict_count = mispredict_count;

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the pipelined branch unit. Adds a fetch-side predictor (2-bit BHT plus direct-mapped BTB) and an execute-side resolver. The resolver handles BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR, detects mispredictions and issues a registered redirect/flush to fetch. It updates the tables and keeps performance counters.

Parameters:
XLEN, 32, datapath and PC width
BHT_ENTRIES, 64, number of 2-bit counters; power of two, >= 2
BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2, <= BHT_ENTRIES
Derived, not overridable: BHT_IDX = log2(BHT_ENTRIES), BTB_IDX = log2(BTB_ENTRIES), TAG_W = XLEN-2-BTB_IDX

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_if_pc  in  XLEN  fetch PC for lookup
o_pred_take  out  1  prediction: taken
o_pred_target  out  XLEN  predicted next PC
i_ex_valid  in  1  a valid instruction is in execute this cycle
i_ex_isBranch  in  1  conditional branch
i_ex_isJal  in  1  JAL
i_ex_isJalr  in  1  JALR
i_ex_funct3  in  3  branch condition
i_ex_pc  in  XLEN  PC of the execute instruction
i_ex_rs1  in  XLEN  rs1 operand (forwarded)
i_ex_rs2  in  XLEN  rs2 operand (forwarded)
i_ex_imm  in  XLEN  sign-extended immediate
i_ex_pred_take  in  1  prediction carried down the pipe with this instruction
i_ex_pred_target  in  XLEN  predicted target carried down the pipe
o_flush  out  1  registered; kill younger instructions, redirect fetch
o_redirect_pc  out  XLEN  registered; correct next PC, valid when o_flush=1
o_branch_count  out  32  resolved control-flow instructions, wraps
o_mispredict_count  out  32  mispredictions, wraps

Behaviour:
- Reset (async, i_rst_n=0): all BHT counters = 2'b01 (weakly not-taken); all BTB valid bits = 0; o_flush=0; o_redirect_pc=0; both counters=0. Deasserting reset in the middle of an operation discards any pending flush.
- Indexing: BHT index = pc[BHT_IDX+1:2]; BTB index = pc[BTB_IDX+1:2]; BTB tag = pc[XLEN-1:BTB_IDX+2]. Each BTB entry holds {valid, isJump, tag, target}.
- Lookup is combinational from i_if_pc, with zero latency.
  - hit = valid && tag match.
  - o_pred_take = hit && (isJump || bht[idx][1]).
  - o_pred_target = o_pred_take ? btb.target : i_if_pc+4.
- Resolve is combinational in the execute cycle and evaluated only when i_ex_valid=1.
  - Branch taken per funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - funct3 010/011 with isBranch: treat as a non-control-flow instruction (not taken, no table update).
  - Actual target: branch/JAL = pc+imm; JALR = (rs1+imm) & ~1. All sums are modulo 2^XLEN.
  - Not taken, or not control flow: actual next = pc+4.
  - Priority if more than one type flag is set: JALR > JAL > branch.
- Mispredict when act_take != i_ex_pred_take, or when both are taken and target != i_ex_pred_target. This includes a non-control-flow instruction predicted taken because of BTB aliasing.
- On mispredict: at the next rising edge o_flush=1 and o_redirect_pc = actual next PC, both held for exactly 1 cycle. Otherwise o_flush=0 and o_redirect_pc holds its last value. Back-to-back mispredicts give consecutive single-cycle flushes.
- Table update happens at the rising edge of a resolving cycle.
  - Valid branch: BHT counter saturates up if taken, down if not (00 floor, 11 ceiling).
  - Taken branch/JAL/JALR: write BTB entry {1, isJal|isJalr, tag, actual target}.
  - Not-taken branch: BTB unchanged.
  - Non-control-flow instruction that hit the BTB (aliasing mispredict): clear that entry's valid bit.
- Same-cycle lookup and update at the same index: lookup returns pre-update contents (write-after-read).
- Counters: o_branch_count +1 per valid branch/JAL/JALR; o_mispredict_count +1 per mispredict; both wrap 0xFFFFFFFF -> 0.
- No internal stall handling: the pipeline deasserts i_ex_valid for bubbles and flushed slots.

Test Plan:
- Reset, then lookup pc=0x100 -> o_pred_take=0, o_pred_target=0x104. Resolve BEQ at 0x100, rs1=rs2=5, imm=0x40, pred_take=0 -> next cycle o_flush=1, o_redirect_pc=0x140, mispredict_count=1; BHT[0x100] goes 01->10.
- Lookup 0x100 after the above -> o_pred_take=1, target=0x140. Resolve the same BEQ with pred 1/0x140 -> o_flush=0.
- JALR at 0x200, rs1=0x1003, imm=0x10, pred_take=0 -> o_redirect_pc=0x1012 (LSB cleared). BTB entry isJump=1; next lookup 0x200 predicts 0x1012 regardless of BHT.
- BLT signed rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken. funct3=010 -> no update, no flush when pred_take=0.
- Saturation: 4 taken resolves at one PC -> counter stays 11; 5 not-taken -> stays 00. Aliasing: PC sharing a BTB index with a non-branch predicted taken -> flush to pc+4, entry invalidated.
- Assert i_rst_n low in the cycle after a mispredict -> o_flush=0 immediately and all counters 0. Preload o_mispredict_count near 0xFFFFFFFF by forcing, then one more mispredict -> wraps to 0.
